// File: rtl/load_stall_multi_ctrl_if.sv
// Bundle of IF/ID, ID/EX and control signals exchanged between the
// pipeline datapath and the load-stall / multi-register sequencer.
interface load_stall_multi_ctrl_if #(
  parameter int REG_W  = 3,
  parameter int LIST_W = 8
);
  logic              if_id_valid;
  logic [5:0]        if_id_op;
  logic [REG_W-1:0]  if_id_regA;
  logic [REG_W-1:0]  if_id_regB;
  logic [LIST_W-1:0] if_id_imm;
  logic [5:0]        id_ex_op;
  logic [REG_W-1:0]  id_ex_regA;
  logic              flush_in;
  logic              pc_we;
  logic              if_id_we;
  logic              id_ex_bubble;
  logic              uop_valid;
  logic [REG_W-1:0]  uop_reg;
  logic [REG_W-1:0]  uop_offset;

  // Pipeline side: presents decode/execute fields, consumes stall controls
  modport master (
    output if_id_valid, if_id_op, if_id_regA, if_id_regB, if_id_imm,
           id_ex_op, id_ex_regA, flush_in,
    input  pc_we, if_id_we, id_ex_bubble, uop_valid, uop_reg, uop_offset
  );

  // Controller side
  modport slave (
    input  if_id_valid, if_id_op, if_id_regA, if_id_regB, if_id_imm,
           id_ex_op, id_ex_regA, flush_in,
    output pc_we, if_id_we, id_ex_bubble, uop_valid, uop_reg, uop_offset
  );
endinterface

// File: rtl/load_stall_multi_ctrl.sv
// Decode-stage interlock: stalls on load-use hazards and expands LM/SM
// into one micro-op per register-list bit while holding fetch.
module load_stall_multi_ctrl #(
  parameter int REG_W  = 3,
  parameter int LIST_W = 8
) (
  input logic                   clk,
  input logic                   reset,
  load_stall_multi_ctrl_if.slave bus
);

  typedef enum logic {IDLE, MULTI} state_t;

  state_t            state_q, state_d;
  logic [LIST_W-1:0] mask_q, mask_d;
  logic [REG_W-1:0]  cnt_q, cnt_d;

  logic              use_a, use_b;
  logic              load_use, is_multi;
  logic [REG_W-1:0]  low_idx;
  logic              low_found;
  logic [LIST_W-1:0] mask_rest;

  logic              pc_we, if_id_we, bubble, uop_valid;
  logic [REG_W-1:0]  uop_reg, uop_offset;

  // Source-register usage of the instruction in IF/ID, and hazard detection
  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    case (bus.if_id_op[5:2])
      4'b0000, 4'b0010, 4'b1100: begin use_a = 1'b1; use_b = 1'b1; end
      4'b0001, 4'b0110, 4'b0111: use_a = 1'b1;
      4'b0100, 4'b0101, 4'b1001: use_b = 1'b1;
      default: ;
    endcase
    load_use = bus.if_id_valid && (bus.id_ex_op[5:2] == 4'b0100) &&
               ((use_a && (bus.if_id_regA == bus.id_ex_regA)) ||
                (use_b && (bus.if_id_regB == bus.id_ex_regA)));
    is_multi = bus.if_id_valid &&
               ((bus.if_id_op[5:2] == 4'b0110) || (bus.if_id_op[5:2] == 4'b0111));
  end

  // Lowest set bit of the remaining register list
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < LIST_W; i++) begin
      if (mask_q[i] && !low_found) begin
        low_idx   = REG_W'(i);
        low_found = 1'b1;
      end
    end
    mask_rest = mask_q & (mask_q - LIST_W'(1));
  end

  // State, list mask and micro-op ordinal registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline controls; reset forces the safe stall values
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    pc_we      = 1'b1;
    if_id_we   = 1'b1;
    bubble     = 1'b0;
    uop_valid  = 1'b0;
    uop_reg    = '0;
    uop_offset = '0;
    case (state_q)
      IDLE: begin
        if (bus.flush_in) begin
          // killed instruction: no hazard check
        end else if (load_use) begin
          pc_we    = 1'b0;
          if_id_we = 1'b0;
          bubble   = 1'b1;
        end else if (is_multi) begin
          bubble = 1'b1;
          if (bus.if_id_imm != '0) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            mask_d   = bus.if_id_imm;
            cnt_d    = '0;
            state_d  = MULTI;
          end
        end
      end
      MULTI: begin
        if (bus.flush_in) begin
          bubble  = 1'b1;
          mask_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          uop_valid  = 1'b1;
          uop_reg    = low_idx;
          uop_offset = cnt_q;
          mask_d     = mask_rest;
          cnt_d      = cnt_q + REG_W'(1);
          if (mask_rest == '0) begin
            state_d = IDLE;
          end else begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      pc_we      = 1'b0;
      if_id_we   = 1'b0;
      bubble     = 1'b1;
      uop_valid  = 1'b0;
      uop_reg    = '0;
      uop_offset = '0;
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.if_id_we     = if_id_we;
  assign bus.id_ex_bubble = bubble;
  assign bus.uop_valid    = uop_valid;
  assign bus.uop_reg      = uop_reg;
  assign bus.uop_offset   = uop_offset;

endmodule
